// File: rtl/detector_borda_pkg.sv
// Shared constants for the multi-channel edge detector: detect-mode encodings
// and the debounce counter width helper.
package detector_borda_pkg;

  localparam logic [1:0] MODE_OFF  = 2'b00;
  localparam logic [1:0] MODE_RISE = 2'b01;
  localparam logic [1:0] MODE_FALL = 2'b10;
  localparam logic [1:0] MODE_BOTH = 2'b11;

  // Counter must hold 0..n-1, with at least one bit even when n is 1.
  function automatic int cnt_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/detector_borda_canal.sv
// One detector channel: synchroniser chain, debounce filter, mode-gated edge
// pulse, and the sticky/overrun flags fed by that pulse.
module detector_borda_canal
  import detector_borda_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int DEBOUNCE    = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       entrada,
  input  logic [1:0] mode,
  input  logic       en,
  input  logic       clr,
  output logic       detector,
  output logic       level,
  output logic       sticky,
  output logic       ovr
);

  localparam int CW = cnt_width(DEBOUNCE);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE - 1);

  logic          s;
  logic [CW-1:0] cnt;
  logic          accept;
  logic          ev;

  generate
    if (SYNC_STAGES == 0) begin : g_nosync
      assign s = entrada;
    end else begin : g_sync
      logic [SYNC_STAGES-1:0] sync_q;
      always_ff @(posedge clk) begin
        if (!rst) begin
          sync_q <= '0;
        end else begin
          sync_q[0] <= entrada;
          for (int k = 1; k < SYNC_STAGES; k++) begin
            sync_q[k] <= sync_q[k-1];
          end
        end
      end
      assign s = sync_q[SYNC_STAGES-1];
    end
  endgenerate

  // A new level is taken only after DEBOUNCE consecutive differing samples;
  // the edge direction is simply the level being accepted.
  assign accept = (s != level) && (cnt == CNT_LAST);
  assign ev     = en & accept & ((s & mode[0]) | (~s & mode[1]));

  always_ff @(posedge clk) begin
    if (!rst) begin
      level    <= 1'b0;
      cnt      <= '0;
      detector <= 1'b0;
      sticky   <= 1'b0;
      ovr      <= 1'b0;
    end else begin
      if (s == level) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        level <= s;
        cnt   <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end
      detector <= ev;
      // A new event outranks a simultaneous clear so it is never lost.
      sticky   <= ev | (sticky & ~clr);
      ovr      <= (ev & sticky & ~clr) | (ovr & ~clr);
    end
  end

endmodule

// File: rtl/detector_borda_multi.sv
// Multi-channel edge detector: WIDTH independent channels plus an interrupt
// that is the OR of all sticky flags.
module detector_borda_multi
  import detector_borda_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2,
  parameter int DEBOUNCE    = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] entrada,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] en,
  input  logic [WIDTH-1:0] clr,
  output logic [WIDTH-1:0] detector,
  output logic [WIDTH-1:0] level,
  output logic [WIDTH-1:0] sticky,
  output logic [WIDTH-1:0] ovr,
  output logic             irq
);

  generate
    for (genvar i = 0; i < WIDTH; i++) begin : g_canal
      detector_borda_canal #(
        .SYNC_STAGES (SYNC_STAGES),
        .DEBOUNCE    (DEBOUNCE)
      ) u_canal (
        .clk      (clk),
        .rst      (rst),
        .entrada  (entrada[i]),
        .mode     (mode),
        .en       (en[i]),
        .clr      (clr[i]),
        .detector (detector[i]),
        .level    (level[i]),
        .sticky   (sticky[i]),
        .ovr      (ovr[i])
      );
    end
  endgenerate

  assign irq = |sticky;

endmodule

// File: tb/tb_detector_borda_multi.sv
// Bench for detector_borda_multi: directed plan steps followed by a random
// phase, all checked against a sample-history reference model.
module tb_detector_borda_multi;
  import detector_borda_pkg::*;

  localparam int W  = 8;
  localparam int SS = 2;
  localparam int DB = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] entrada;
  logic [1:0]   mode;
  logic [W-1:0] en;
  logic [W-1:0] clr;
  logic [W-1:0] detector;
  logic [W-1:0] level;
  logic [W-1:0] sticky;
  logic [W-1:0] ovr;
  logic         irq;

  detector_borda_multi #(
    .WIDTH       (W),
    .SYNC_STAGES (SS),
    .DEBOUNCE    (DB)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .entrada  (entrada),
    .mode     (mode),
    .en       (en),
    .clr      (clr),
    .detector (detector),
    .level    (level),
    .sticky   (sticky),
    .ovr      (ovr),
    .irq      (irq)
  );

  // clock / reset
  always #5 clk = ~clk;

  int vectors    = 0;
  int miscompares = 0;

  // reference model state
  logic [W-1:0] exp_q[$];
  logic [W-1:0] hist[$];
  logic [W-1:0] m_lvl, m_sticky, m_ovr;
  int           run[W];
  int           pcnt[W];

  function automatic bit mode_wants(input logic [1:0] md, input logic new_lvl);
    if (new_lvl) return (md == MODE_RISE) || (md == MODE_BOTH);
    else         return (md == MODE_FALL) || (md == MODE_BOTH);
  endfunction

  task automatic model_reset();
    hist = {};
    for (int k = 0; k < SS; k++) hist.push_back('0);
    m_lvl = '0; m_sticky = '0; m_ovr = '0;
    for (int i = 0; i < W; i++) run[i] = 0;
  endtask

  // Advances the model by one clock using the inputs seen at that edge.
  task automatic model_update();
    logic [W-1:0] s;
    logic [W-1:0] ev;
    if (!rst) begin
      model_reset();
      exp_q.push_back('0);
      return;
    end
    if (SS == 0) s = entrada;
    else begin
      s = hist[0];
      hist.push_back(entrada);
      void'(hist.pop_front());
    end
    ev = '0;
    for (int i = 0; i < W; i++) begin
      if (s[i] != m_lvl[i]) begin
        run[i]++;
        if (run[i] == DB) begin
          m_lvl[i] = s[i];
          run[i]   = 0;
          if (en[i] && mode_wants(mode, s[i])) ev[i] = 1'b1;
        end
      end else begin
        run[i] = 0;
      end
    end
    for (int i = 0; i < W; i++) begin
      if (ev[i]) begin
        if (clr[i])           m_ovr[i] = 1'b0;
        else if (m_sticky[i]) m_ovr[i] = 1'b1;
        m_sticky[i] = 1'b1;
      end else if (clr[i]) begin
        m_sticky[i] = 1'b0;
        m_ovr[i]    = 1'b0;
      end
    end
    exp_q.push_back(ev);
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic check_all();
    logic [W-1:0] e;
    e = exp_q.pop_front();
    chk("detector", 32'(detector), 32'(e));
    chk("level",    32'(level),    32'(m_lvl));
    chk("sticky",   32'(sticky),   32'(m_sticky));
    chk("ovr",      32'(ovr),      32'(m_ovr));
    chk("irq",      32'(irq),      32'(|m_sticky));
    for (int i = 0; i < W; i++) if (detector[i] === 1'b1) pcnt[i]++;
  endtask

  // driver tasks
  task automatic tick();
    @(posedge clk);
    model_update();
    #1;
    check_all();
  endtask

  task automatic run_n(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  task automatic clear_counts();
    for (int i = 0; i < W; i++) pcnt[i] = 0;
  endtask

  task automatic clear_all_flags();
    clr = '1; tick(); clr = '0;
  endtask

  initial begin
    rst = 1'b0; entrada = '1; mode = MODE_RISE; en = '1; clr = '0;
    model_reset();
    clear_counts();

    // reset with inputs held high
    run_n(3);
    chk("reset_outputs", 32'({detector, level, sticky, ovr, irq}), 32'd0);
    rst = 1'b1;
    run_n(SS + DB - 1);
    chk("pre_latency_det", 32'(detector), 32'd0);
    tick();
    chk("latency_det", 32'(detector), 32'hFF);
    run_n(10);
    for (int i = 0; i < W; i++) chk("reset_rise_count", 32'(pcnt[i]), 32'd1);

    // settle low, clear flags
    entrada = '0;
    run_n(12);
    clear_all_flags();
    clear_counts();

    // glitch shorter than debounce
    entrada[0] = 1'b1; run_n(3);
    entrada[0] = 1'b0; run_n(15);
    chk("glitch_pulses", 32'(pcnt[0]), 32'd0);
    chk("glitch_level", 32'(level[0]), 32'd0);
    entrada[0] = 1'b1; run_n(4);
    entrada[0] = 1'b0; run_n(2);
    chk("hold4_level", 32'(level[0]), 32'd1);
    run_n(15);
    chk("hold4_pulses", 32'(pcnt[0]), 32'd1);

    // modes on ch2
    for (int m = 0; m < 4; m++) begin
      logic [1:0] md;
      md = 2'(m);
      mode = md;
      clear_counts();
      entrada[2] = 1'b1; run_n(10);
      chk("mode_level_hi", 32'(level[2]), 32'd1);
      entrada[2] = 1'b0; run_n(10);
      chk("mode_level_lo", 32'(level[2]), 32'd0);
      chk("mode_pulses", 32'(pcnt[2]), (md == MODE_OFF) ? 32'd0 : (md == MODE_BOTH) ? 32'd2 : 32'd1);
    end

    // sticky / overrun on ch1
    mode = MODE_RISE;
    clear_all_flags();
    for (int k = 0; k < 2; k++) begin
      entrada[1] = 1'b1; run_n(10);
      entrada[1] = 1'b0; run_n(10);
    end
    chk("ovr_flags", 32'({sticky[1], ovr[1], irq}), 32'b111);
    clr[1] = 1'b1; tick(); clr[1] = 1'b0;
    chk("clr_flags", 32'({sticky[1], ovr[1], irq}), 32'b000);

    // clear coinciding with an event on ch3
    mode = MODE_BOTH;
    entrada[3] = 1'b1; run_n(10);
    chk("ch3_first_sticky", 32'(sticky[3]), 32'd1);
    entrada[3] = 1'b0; run_n(SS + DB - 1);
    clr[3] = 1'b1; tick(); clr[3] = 1'b0;
    chk("simul_det", 32'(detector[3]), 32'd1);
    chk("simul_flags", 32'({sticky[3], ovr[3]}), 32'b10);

    // enable gating on ch5
    mode = MODE_RISE;
    clear_all_flags();
    clear_counts();
    en[5] = 1'b0;
    entrada[5] = 1'b1; run_n(10);
    chk("en_level", 32'(level[5]), 32'd1);
    chk("en_sticky", 32'(sticky[5]), 32'd0);
    en[5] = 1'b1; run_n(10);
    chk("en_no_late_pulse", 32'(pcnt[5]), 32'd0);

    // random phase
    for (int c = 0; c < 600; c++) begin
      for (int i = 0; i < W; i++)
        if ($urandom_range(0, 5) == 0) entrada[i] = ~entrada[i];
      if ($urandom_range(0, 40) == 0) mode = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 20) == 0) en = W'($urandom);
      clr = '0;
      if ($urandom_range(0, 8) == 0) clr = W'($urandom) & W'($urandom);
      rst = ($urandom_range(0, 150) == 0) ? 1'b0 : 1'b1;
      tick();
    end
    rst = 1'b1; clr = '0;
    run_n(5);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
